// File: rtl/demux_rr_dispatcher_pkg.sv
// demux_rr_dispatcher_pkg
//   Shared type definitions for the round-robin / directed dispatch stage.
//   Widths are not defined here; every module derives them from its own
//   p_nbits / p_noutputs parameters.
package demux_rr_dispatcher_pkg;

    // Steering mode as seen by the dispatcher; cfg_rr maps straight onto it.
    typedef enum logic {
        STEER_DIRECTED = 1'b0,
        STEER_RR       = 1'b1
    } steer_mode_e;

endpackage

// File: rtl/demux_lane_buf.sv
// demux_lane_buf
//   One-entry val/rdy buffer for a single dispatcher output lane.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     load, load_msg  write enable and data from the dispatcher
//     send_rdy        downstream ready for this lane
//     send_val        lane holds an undelivered message (full flag)
//     send_msg        buffered message, stable while held
module demux_lane_buf #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [p_nbits-1:0] load_msg,
    input  logic               send_rdy,
    output logic               send_val,
    output logic [p_nbits-1:0] send_msg
);

    logic               full_q, full_d;
    logic [p_nbits-1:0] data_q, data_d;

    // A drain clears the entry, but a load in the same cycle wins so the
    // lane can pass one message per cycle (flow-through refill).
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && send_rdy) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = load_msg;
        end
    end

    // Buffer state; reset discards anything still held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign send_val = full_q;
    assign send_msg = data_q;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
//   Steers one val/rdy message stream onto p_noutputs buffered lanes, either
//   in strict round-robin order (cfg_rr=1) or by recv_sel (cfg_rr=0).
//   Ports:
//     clk, reset                   clock, asynchronous active-high reset
//     cfg_rr                       steering mode select
//     recv_msg/recv_sel/recv_val   input message, directed target, valid
//     recv_rdy                     input ready (combinational from send_rdy)
//     send_msg/send_val/send_rdy   flattened lane data, per-lane valid/ready
//     rr_ptr                       current round-robin target lane
//     drop_err                     one-cycle pulse per discarded out-of-range message
module demux_rr_dispatcher
    import demux_rr_dispatcher_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_noutputs = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_rr,
    input  logic [p_nbits-1:0]              recv_msg,
    input  logic [$clog2(p_noutputs)-1:0]   recv_sel,
    input  logic                            recv_val,
    output logic                            recv_rdy,
    output logic [p_noutputs*p_nbits-1:0]   send_msg,
    output logic [p_noutputs-1:0]           send_val,
    input  logic [p_noutputs-1:0]           send_rdy,
    output logic [$clog2(p_noutputs)-1:0]   rr_ptr,
    output logic                            drop_err
);

    localparam int SW = $clog2(p_noutputs);

    steer_mode_e          mode;
    logic [SW-1:0]        tgt;
    logic                 in_range;
    logic                 lane_rdy;
    logic                 accept;
    logic [p_noutputs-1:0] load;
    logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 drop_err_q, drop_err_d;

    assign mode = steer_mode_e'(cfg_rr);
    assign tgt  = (mode == STEER_RR) ? rr_ptr_q : recv_sel;

    // Only non-power-of-two lane counts can produce an unreachable select.
    if ((1 << SW) == p_noutputs) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = ({1'b0, tgt} < (SW+1)'(p_noutputs));
    end

    // Ready of the targeted lane: empty, or full but draining this cycle.
    always_comb begin
        lane_rdy = 1'b0;
        for (int i = 0; i < p_noutputs; i++) begin
            if (tgt == SW'(i)) begin
                lane_rdy = ~send_val[i] | send_rdy[i];
            end
        end
    end

    // Out-of-range directed messages are always consumed so they get dropped.
    assign recv_rdy = in_range ? lane_rdy : 1'b1;
    assign accept   = recv_val & recv_rdy;

    always_comb begin
        load = '0;
        for (int i = 0; i < p_noutputs; i++) begin
            load[i] = accept & in_range & (tgt == SW'(i));
        end
    end

    // Pointer only moves on round-robin accepts; directed traffic and mode
    // switches leave it where it was.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        drop_err_d = recv_val & ~in_range;
        if (accept && (mode == STEER_RR)) begin
            rr_ptr_d = (rr_ptr_q == SW'(p_noutputs - 1)) ? '0 : rr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign rr_ptr   = rr_ptr_q;
    assign drop_err = drop_err_q;

    for (genvar i = 0; i < p_noutputs; i++) begin : g_lane
        demux_lane_buf #(.p_nbits(p_nbits)) u_buf (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .load_msg (recv_msg),
            .send_rdy (send_rdy[i]),
            .send_val (send_val[i]),
            .send_msg (send_msg[i*p_nbits +: p_nbits])
        );
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher
//   Directed bench for demux_rr_dispatcher: a 4-lane instance for the main
//   round-robin / directed traffic and a 3-lane instance for dropped selects.
module tb_demux_rr_dispatcher;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // 4-lane instance
   logic        cfg_rr = 1'b1;
   logic [31:0] recv_msg = '0;
   logic [1:0]  recv_sel = '0;
   logic        recv_val = 1'b0;
   logic        recv_rdy;
   logic [127:0] send_msg;
   logic [3:0]  send_val;
   logic [3:0]  send_rdy = 4'b0000;
   logic [1:0]  rr_ptr;
   logic        drop_err;

   // 3-lane instance
   logic        cfg_rr3 = 1'b0;
   logic [31:0] recv_msg3 = '0;
   logic [1:0]  recv_sel3 = '0;
   logic        recv_val3 = 1'b0;
   logic        recv_rdy3;
   logic [95:0] send_msg3;
   logic [2:0]  send_val3;
   logic [2:0]  send_rdy3 = 3'b111;
   logic [1:0]  rr_ptr3;
   logic        drop_err3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   demux_rr_dispatcher #(.p_nbits(32), .p_noutputs(4)) dut (
      .clk(clk), .reset(reset), .cfg_rr(cfg_rr),
      .recv_msg(recv_msg), .recv_sel(recv_sel), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
      .rr_ptr(rr_ptr), .drop_err(drop_err)
   );

   demux_rr_dispatcher #(.p_nbits(32), .p_noutputs(3)) dut3 (
      .clk(clk), .reset(reset), .cfg_rr(cfg_rr3),
      .recv_msg(recv_msg3), .recv_sel(recv_sel3), .recv_val(recv_val3), .recv_rdy(recv_rdy3),
      .send_msg(send_msg3), .send_val(send_val3), .send_rdy(send_rdy3),
      .rr_ptr(rr_ptr3), .drop_err(drop_err3)
   );

   function automatic logic [31:0] lane(input int i);
      return send_msg[i*32 +: 32];
   endfunction

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // After reset every lane is empty, pointer at 0, input ready.
   task automatic test_reset();
      checks++; if (send_val !== 4'b0000) begin errors++; $display("[TB] FAIL reset_send_val got=%b exp=0000", send_val); end
      checks++; if (send_msg !== 128'd0) begin errors++; $display("[TB] FAIL reset_send_msg got=%h exp=0", send_msg); end
      checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL reset_rr_ptr got=%0d exp=0", rr_ptr); end
      checks++; if (drop_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop_err got=%b exp=0", drop_err); end
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_recv_rdy got=%b exp=1", recv_rdy); end
      checks++; if (send_val3 !== 3'b000) begin errors++; $display("[TB] FAIL reset_send_val3 got=%b exp=000", send_val3); end
   endtask

   // Eight back-to-back round-robin messages with all lanes draining.
   task automatic test_rr_back_to_back();
      logic [3:0] exp_val;
      cfg_rr = 1'b1; send_rdy = 4'b1111; recv_val = 1'b1;
      for (int k = 0; k < 8; k++) begin
         recv_msg = 32'hA0 + 32'(k);
         #1;
         checks++; if (recv_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rr_b2b_rdy k=%0d got=%b exp=1", k, recv_rdy); end
         checks++; if (rr_ptr !== 2'(k % 4)) begin errors++; $display("[TB] FAIL rr_b2b_ptr k=%0d got=%0d exp=%0d", k, rr_ptr, k % 4); end
         tick();
         exp_val = 4'b0001 << (k % 4);
         checks++; if (send_val !== exp_val) begin errors++; $display("[TB] FAIL rr_b2b_val k=%0d got=%b exp=%b", k, send_val, exp_val); end
         checks++; if (lane(k % 4) !== 32'hA0 + 32'(k)) begin errors++; $display("[TB] FAIL rr_b2b_msg k=%0d got=%h exp=%h", k, lane(k % 4), 32'hA0 + 32'(k)); end
      end
      recv_val = 1'b0;
      tick();
      checks++; if (send_val !== 4'b0000) begin errors++; $display("[TB] FAIL rr_b2b_drain got=%b exp=0000", send_val); end
      checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rr_b2b_wrap got=%0d exp=0", rr_ptr); end
   endtask

   // Lane 1 blocked: strict order stalls when the pointer comes back to it.
   task automatic test_rr_stall();
      logic [3:0] exp_val [5] = '{4'b0001, 4'b0010, 4'b0110, 4'b1010, 4'b0011};
      cfg_rr = 1'b1; send_rdy = 4'b1101; recv_val = 1'b1;
      for (int k = 0; k < 5; k++) begin
         recv_msg = 32'h10 + 32'(k);
         #1;
         checks++; if (recv_rdy !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_rdy k=%0d got=%b exp=1", k, recv_rdy); end
         tick();
         checks++; if (send_val !== exp_val[k]) begin errors++; $display("[TB] FAIL stall_val k=%0d got=%b exp=%b", k, send_val, exp_val[k]); end
      end
      checks++; if (lane(1) !== 32'h11) begin errors++; $display("[TB] FAIL stall_lane1_hold got=%h exp=11", lane(1)); end
      recv_msg = 32'h15;
      for (int k = 0; k < 2; k++) begin
         checks++; if (recv_rdy !== 1'b0) begin errors++; $display("[TB] FAIL stall_rdy k=%0d got=%b exp=0", k, recv_rdy); end
         tick();
         checks++; if (rr_ptr !== 2'd1) begin errors++; $display("[TB] FAIL stall_ptr k=%0d got=%0d exp=1", k, rr_ptr); end
         checks++; if (send_val !== 4'b0010 || lane(1) !== 32'h11) begin errors++; $display("[TB] FAIL stall_hold k=%0d got=%b/%h exp=0010/11", k, send_val, lane(1)); end
      end
      send_rdy = 4'b1111;
      #1;
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_rdy got=%b exp=1", recv_rdy); end
      tick();
      checks++; if (send_val !== 4'b0010 || lane(1) !== 32'h15) begin errors++; $display("[TB] FAIL stall_flow got=%b/%h exp=0010/15", send_val, lane(1)); end
      checks++; if (rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL stall_ptr_after got=%0d exp=2", rr_ptr); end
      recv_val = 1'b0;
      tick();
      checks++; if (send_val !== 4'b0000) begin errors++; $display("[TB] FAIL stall_drain got=%b exp=0000", send_val); end
   endtask

   // Directed to lane 2: blocked while full, flow-through once it drains.
   task automatic test_directed_flow();
      cfg_rr = 1'b0; recv_sel = 2'd2; send_rdy = 4'b0000; recv_val = 1'b1; recv_msg = 32'h20;
      tick();
      checks++; if (send_val !== 4'b0100 || lane(2) !== 32'h20) begin errors++; $display("[TB] FAIL dir_first got=%b/%h exp=0100/20", send_val, lane(2)); end
      checks++; if (rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL dir_ptr_hold got=%0d exp=2", rr_ptr); end
      recv_msg = 32'h21;
      #1;
      checks++; if (recv_rdy !== 1'b0) begin errors++; $display("[TB] FAIL dir_blocked got=%b exp=0", recv_rdy); end
      send_rdy = 4'b0100;
      for (int k = 1; k <= 4; k++) begin
         recv_msg = 32'h20 + 32'(k);
         #1;
         checks++; if (recv_rdy !== 1'b1) begin errors++; $display("[TB] FAIL dir_flow_rdy k=%0d got=%b exp=1", k, recv_rdy); end
         tick();
         checks++; if (send_val !== 4'b0100 || lane(2) !== 32'h20 + 32'(k)) begin errors++; $display("[TB] FAIL dir_flow k=%0d got=%b/%h exp=0100/%h", k, send_val, lane(2), 32'h20 + 32'(k)); end
      end
      recv_val = 1'b0;
      tick();
      checks++; if (send_val !== 4'b0000) begin errors++; $display("[TB] FAIL dir_drain got=%b exp=0000", send_val); end
      checks++; if (rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL dir_ptr_end got=%0d exp=2", rr_ptr); end
   endtask

   // Mode switch 1->0->1 keeps the pointer at lane 2.
   task automatic test_mode_switch();
      send_rdy = 4'b1111; recv_val = 1'b1;
      cfg_rr = 1'b0; recv_sel = 2'd0; recv_msg = 32'h30;
      tick();
      checks++; if (send_val !== 4'b0001 || lane(0) !== 32'h30 || rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL switch_dir0 got=%b/%h/%0d exp=0001/30/2", send_val, lane(0), rr_ptr); end
      recv_sel = 2'd3; recv_msg = 32'h31;
      tick();
      checks++; if (send_val !== 4'b1000 || lane(3) !== 32'h31 || rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL switch_dir3 got=%b/%h/%0d exp=1000/31/2", send_val, lane(3), rr_ptr); end
      cfg_rr = 1'b1; recv_msg = 32'h32;
      tick();
      checks++; if (send_val !== 4'b0100 || lane(2) !== 32'h32) begin errors++; $display("[TB] FAIL switch_rr got=%b/%h exp=0100/32", send_val, lane(2)); end
      checks++; if (rr_ptr !== 2'd3) begin errors++; $display("[TB] FAIL switch_rr_ptr got=%0d exp=3", rr_ptr); end
      recv_val = 1'b0;
      tick();
   endtask

   // 3-lane instance: select 3 is consumed, dropped, and flagged once.
   task automatic test_out_of_range();
      cfg_rr3 = 1'b0; recv_sel3 = 2'd3; recv_msg3 = 32'h55; recv_val3 = 1'b1;
      #1;
      checks++; if (recv_rdy3 !== 1'b1) begin errors++; $display("[TB] FAIL oor_rdy got=%b exp=1", recv_rdy3); end
      checks++; if (drop_err3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_pre_err got=%b exp=0", drop_err3); end
      tick();
      recv_val3 = 1'b0;
      checks++; if (drop_err3 !== 1'b1) begin errors++; $display("[TB] FAIL oor_err_pulse got=%b exp=1", drop_err3); end
      checks++; if (send_val3 !== 3'b000) begin errors++; $display("[TB] FAIL oor_no_lane got=%b exp=000", send_val3); end
      checks++; if (rr_ptr3 !== 2'd0) begin errors++; $display("[TB] FAIL oor_ptr got=%0d exp=0", rr_ptr3); end
      tick();
      checks++; if (drop_err3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_end got=%b exp=0", drop_err3); end
      recv_sel3 = 2'd1; recv_msg3 = 32'h56; recv_val3 = 1'b1;
      tick();
      recv_val3 = 1'b0;
      checks++; if (send_val3 !== 3'b010 || send_msg3[63:32] !== 32'h56 || drop_err3 !== 1'b0) begin errors++; $display("[TB] FAIL oor_inrange got=%b/%h/%b exp=010/56/0", send_val3, send_msg3[63:32], drop_err3); end
      tick();
   endtask

   // Asynchronous reset between edges discards held lanes 0 and 2.
   task automatic test_reset_mid();
      cfg_rr = 1'b0; send_rdy = 4'b0000; recv_val = 1'b1;
      recv_sel = 2'd0; recv_msg = 32'h40;
      tick();
      recv_sel = 2'd2; recv_msg = 32'h42;
      tick();
      recv_val = 1'b0;
      checks++; if (send_val !== 4'b0101) begin errors++; $display("[TB] FAIL rst_mid_setup got=%b exp=0101", send_val); end
      #2 reset = 1'b1;
      #1;
      checks++; if (send_val !== 4'b0000 || rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_async got=%b/%0d exp=0000/0", send_val, rr_ptr); end
      checks++; if (send_msg !== 128'd0) begin errors++; $display("[TB] FAIL rst_mid_msg got=%h exp=0", send_msg); end
      #2 reset = 1'b0;
      send_rdy = 4'b1111;
      tick();
      checks++; if (send_val !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_lost got=%b exp=0000", send_val); end
      cfg_rr = 1'b1; recv_val = 1'b1; recv_msg = 32'h50;
      tick();
      recv_val = 1'b0;
      checks++; if (send_val !== 4'b0001 || lane(0) !== 32'h50 || rr_ptr !== 2'd1) begin errors++; $display("[TB] FAIL rst_mid_restart got=%b/%h/%0d exp=0001/50/1", send_val, lane(0), rr_ptr); end
   endtask

   // The 4-lane instance can never drop a message.
   always @(negedge clk) begin
      if (!reset && drop_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drop_err4 got=%b exp=0", drop_err);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      test_reset();
      tick();
      test_rr_back_to_back();
      test_rr_stall();
      test_directed_flow();
      test_mode_switch();
      test_out_of_range();
      test_reset_mid();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
